// File: rtl/mem_pkg.sv
// mem_pkg: shared types and address decode for the SRAM responder.
// Holds the FSM state encoding and the range/index helper.
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ACCESS,
      RDWAIT,
      RESP
   } state_e;

   localparam logic [3:0] WSTRB_NONE = 4'h0;

   typedef struct packed {
      logic        ok;
      logic [29:0] word;
   } decode_t;

   // 33-bit offset so a base near the top of memory cannot wrap.
   function automatic decode_t addr_decode(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [32:0] depth
   );
      logic [32:0] off;
      logic [32:0] span;
      decode_t     r;
      off    = {1'b0, addr} - {1'b0, base};
      span   = {depth[30:0], 2'b00};
      r.ok   = (addr >= base) && (off < span);
      r.word = off[31:2];
      return r;
   endfunction

endpackage

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: valid/ready memory port responder over a 1-cycle SRAM.
// Adds wait states, range checks and fault responses.
module mem_sram_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mem_valid,
   input  logic              mem_instr,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic              mem_fault,
   output logic              sram_en,
   output logic [3:0]        sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic                ready_q, ready_d;
   logic                fault_q, fault_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                en_q, en_d;
   logic [3:0]          we_q, we_d;

   decode_t             dec;
   logic                illegal;
   logic                unused_word_hi;

   assign dec = addr_decode(mem_addr, BASE_ADDR, 33'(DEPTH_WORDS));
   assign illegal = !dec.ok ||
                    (mem_instr && (mem_wstrb != WSTRB_NONE));
   assign unused_word_hi = ^dec.word[29:ADDR_W];

   // Next-state, request latching and registered output values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      fault_d = 1'b0;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (mem_valid) begin
               addr_d  = dec.word[ADDR_W-1:0];
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               if (illegal) begin
                  state_d = RESP;
                  fault_d = 1'b1;
                  rdata_d = 32'h0;
               end else if (WAIT_STATES == 0) begin
                  state_d = ACCESS;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES);
               end
            end
         end
         WAIT: begin
            if (!mem_valid) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q <= 4'd1) begin
               state_d = ACCESS;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACCESS: begin
            if (!mem_valid) begin
               state_d = IDLE;
            end else if (wstrb_q != WSTRB_NONE) begin
               state_d = RESP;
               rdata_d = 32'h0;
            end else begin
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            rdata_d = sram_rdata;
            state_d = mem_valid ? RESP : IDLE;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == RESP);
      en_d    = (state_d == ACCESS);
      we_d    = en_d ? wstrb_d : WSTRB_NONE;
   end

   // State and output registers; reset drops any in-flight request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         wstrb_q <= WSTRB_NONE;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         rdata_q <= 32'h0;
         en_q    <= 1'b0;
         we_q    <= WSTRB_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
         en_q    <= en_d;
         we_q    <= we_d;
      end
   end

   assign mem_ready  = ready_q;
   assign mem_fault  = fault_q;
   assign mem_rdata  = rdata_q;
   assign sram_en    = en_q;
   assign sram_we    = we_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed bench for mem_sram_ctrl.
// One instance with no wait states, one with three and a smaller SRAM.
module tb_mem_sram_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        instr = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   logic        valid0 = 1'b0;
   logic        valid1 = 1'b0;

   logic        ready0, fault0, en0;
   logic [31:0] rdata0, swd0;
   logic [31:0] srd0 = 32'h0;
   logic [3:0]  we0;
   logic [11:0] sa0;

   logic        ready1, fault1, en1;
   logic [31:0] rdata1, swd1;
   logic [31:0] srd1 = 32'h0;
   logic [3:0]  we1;
   logic [7:0]  sa1;

   logic [31:0] ram0 [4096];
   logic [31:0] ram1 [256];

   int checks = 0;
   int errors = 0;

   int          lat;
   logic [31:0] rd;
   logic        flt;
   logic        saw_en;
   logic        seen;

   always #5 clk = ~clk;

   mem_sram_ctrl #(
      .DEPTH_WORDS(4096),
      .BASE_ADDR  (32'h0),
      .WAIT_STATES(0)
   ) u_dut0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .mem_valid (valid0),
      .mem_instr (instr),
      .mem_addr  (addr),
      .mem_wdata (wdata),
      .mem_wstrb (wstrb),
      .mem_ready (ready0),
      .mem_rdata (rdata0),
      .mem_fault (fault0),
      .sram_en   (en0),
      .sram_we   (we0),
      .sram_addr (sa0),
      .sram_wdata(swd0),
      .sram_rdata(srd0)
   );

   mem_sram_ctrl #(
      .DEPTH_WORDS(256),
      .BASE_ADDR  (32'h0),
      .WAIT_STATES(3)
   ) u_dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .mem_valid (valid1),
      .mem_instr (instr),
      .mem_addr  (addr),
      .mem_wdata (wdata),
      .mem_wstrb (wstrb),
      .mem_ready (ready1),
      .mem_rdata (rdata1),
      .mem_fault (fault1),
      .sram_en   (en1),
      .sram_we   (we1),
      .sram_addr (sa1),
      .sram_wdata(swd1),
      .sram_rdata(srd1)
   );

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] nw,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Synchronous SRAM models, one-cycle read latency.
   always @(posedge clk) begin
      if (en0) begin
         if (we0 == 4'h0) srd0 <= ram0[sa0];
         else ram0[sa0] <= merge(ram0[sa0], swd0, we0);
      end
      if (en1) begin
         if (we1 == 4'h0) srd1 <= ram1[sa1];
         else ram1[sa1] <= merge(ram1[sa1], swd1, we1);
      end
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(
      input  bit          d,
      input  logic        i,
      input  logic [31:0] a,
      input  logic [31:0] wd,
      input  logic [3:0]  ws,
      output int          l,
      output logic [31:0] r,
      output logic        f,
      output logic        se
   );
      instr = i;
      addr  = a;
      wdata = wd;
      wstrb = ws;
      if (d) valid1 = 1'b1;
      else valid0 = 1'b1;
      l  = -1;
      r  = 32'hBAD0BAD0;
      f  = 1'bx;
      se = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (d ? en1 : en0) se = 1'b1;
         if (d ? ready1 : ready0) begin
            l = n;
            r = d ? rdata1 : rdata0;
            f = d ? fault1 : fault0;
            break;
         end
      end
      valid0 = 1'b0;
      valid1 = 1'b0;
      instr  = 1'b0;
      wstrb  = 4'h0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 4096; k++) ram0[k] = 32'h0;
      for (int k = 0; k < 256; k++) ram1[k] = 32'h0;

      #1 reset_n = 1'b0;
      #2;
      chk("rst_ready", 32'(ready0), 32'h0);
      chk("rst_fault", 32'(fault0), 32'h0);
      chk("rst_en",    32'(en0),    32'h0);
      chk("rst_we",    32'(we0),    32'h0);
      chk("rst_rdata", rdata0,      32'h0);
      #20;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      do_req(0, 0, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, flt, saw_en);
      chk("wr_lat",   32'(lat), 32'd2);
      chk("wr_fault", 32'(flt), 32'h0);
      chk("wr_rdata", rd,       32'h0);

      do_req(0, 0, 32'h10, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("rd_lat",   32'(lat), 32'd3);
      chk("rd_data",  rd,       32'hDEADBEEF);
      chk("rd_fault", 32'(flt), 32'h0);

      do_req(0, 0, 32'h10, 32'h0000AB00, 4'b0010, lat, rd, flt, saw_en);
      chk("bwr_lat", 32'(lat), 32'd2);
      do_req(0, 0, 32'h10, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("bwr_data", rd, 32'hDEADABEF);

      do_req(0, 0, 32'h4000, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("oor_lat",   32'(lat),    32'd1);
      chk("oor_fault", 32'(flt),    32'h1);
      chk("oor_rdata", rd,          32'h0);
      chk("oor_en",    32'(saw_en), 32'h0);

      do_req(0, 0, 32'h3FFC, 32'h12345678, 4'hF, lat, rd, flt, saw_en);
      chk("top_wr_fault", 32'(flt), 32'h0);
      do_req(0, 0, 32'h3FFC, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("top_rd_data", rd, 32'h12345678);

      do_req(0, 0, 32'h20, 32'h55AA55AA, 4'hF, lat, rd, flt, saw_en);
      chk("pre_wr_fault", 32'(flt), 32'h0);
      do_req(0, 1, 32'h20, 32'h11111111, 4'hF, lat, rd, flt, saw_en);
      chk("iwr_lat",   32'(lat),    32'd1);
      chk("iwr_fault", 32'(flt),    32'h1);
      chk("iwr_en",    32'(saw_en), 32'h0);
      do_req(0, 1, 32'h20, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("ifetch_lat",   32'(lat), 32'd3);
      chk("ifetch_data",  rd,       32'h55AA55AA);
      chk("ifetch_fault", 32'(flt), 32'h0);

      do_req(1, 0, 32'h40, 32'hCAFEF00D, 4'hF, lat, rd, flt, saw_en);
      chk("w3_wr_lat", 32'(lat), 32'd5);
      do_req(1, 0, 32'h40, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("w3_rd_lat",  32'(lat), 32'd6);
      chk("w3_rd_data", rd,       32'hCAFEF00D);
      do_req(1, 0, 32'h400, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("w3_oor_lat",   32'(lat),    32'd1);
      chk("w3_oor_fault", 32'(flt),    32'h1);
      chk("w3_oor_en",    32'(saw_en), 32'h0);

      addr   = 32'h40;
      wstrb  = 4'h0;
      valid1 = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      valid1 = 1'b0;
      seen   = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1;
         if (en1 || ready1) seen = 1'b1;
      end
      chk("abort_quiet", 32'(seen), 32'h0);
      do_req(1, 0, 32'h40, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("abort_next_lat",  32'(lat), 32'd6);
      chk("abort_next_data", rd,       32'hCAFEF00D);

      addr   = 32'h10;
      wstrb  = 4'h0;
      valid0 = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(ready0), 32'h0);
      chk("mid_rst_en",    32'(en0),    32'h0);
      chk("mid_rst_rdata", rdata0,      32'h0);
      valid0 = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      do_req(0, 0, 32'h10, 32'h0, 4'h0, lat, rd, flt, saw_en);
      chk("post_rst_lat",  32'(lat), 32'd3);
      chk("post_rst_data", rd,       32'hDEADABEF);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
